// File: rtl/branch_condition_controller_if.sv
// ============================================================================
//  Module      : branch_condition_controller_if
//  Description : EX-stage <-> branch controller bundle. Carries the EX-stage
//                instruction (valid/ready handshake, opcode, flag write,
//                ALU flags, branch target) and the controller results
//                (condition, architectural flags, redirect, flush).
//  Ports       : (interface signals, named from the controller's viewpoint)
//                ex_valid_i / ex_ready_o    - instruction handshake
//                ex_opcode_i                - 6-bit opcode
//                ex_flag_write_i            - instruction updates NZCV
//                alu_flags_i                - ALU {N,Z,C,V}
//                ex_target_i                - computed branch target
//                cond_ex_o                  - condition holds (comb.)
//                flags_o                    - registered NZCV
//                branch_taken_o             - one-cycle redirect pulse
//                branch_target_o            - redirect PC
//                flush_o                    - squash fetch/decode
//                taken_cnt_o/not_taken_cnt_o- branch statistics
//                                             (only with BRANCH_STATS_EN)
//  Options     : BRANCH_STATS_EN adds the statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_condition_controller_if #(
    parameter int ADDR_W = 32
);
    logic              ex_valid_i;
    logic              ex_ready_o;
    logic [5:0]        ex_opcode_i;
    logic              ex_flag_write_i;
    logic [3:0]        alu_flags_i;
    logic [ADDR_W-1:0] ex_target_i;
    logic              cond_ex_o;
    logic [3:0]        flags_o;
    logic              branch_taken_o;
    logic [ADDR_W-1:0] branch_target_o;
    logic              flush_o;
`ifdef BRANCH_STATS_EN
    logic [15:0]       taken_cnt_o;
    logic [15:0]       not_taken_cnt_o;
`endif

    // Controller side
    modport slave (
        input  ex_valid_i,
        output ex_ready_o,
        input  ex_opcode_i,
        input  ex_flag_write_i,
        input  alu_flags_i,
        input  ex_target_i,
        output cond_ex_o,
        output flags_o,
        output branch_taken_o,
        output branch_target_o,
`ifdef BRANCH_STATS_EN
        output taken_cnt_o,
        output not_taken_cnt_o,
`endif
        output flush_o
    );

    // EX-stage / pipeline side
    modport master (
        output ex_valid_i,
        input  ex_ready_o,
        output ex_opcode_i,
        output ex_flag_write_i,
        output alu_flags_i,
        output ex_target_i,
        input  cond_ex_o,
        input  flags_o,
        input  branch_taken_o,
        input  branch_target_o,
`ifdef BRANCH_STATS_EN
        input  taken_cnt_o,
        input  not_taken_cnt_o,
`endif
        input  flush_o
    );
endinterface

`default_nettype wire

// File: rtl/branch_condition_controller.sv
// ============================================================================
//  Module      : branch_condition_controller
//  Description : Execute-stage branch resolution. Holds the architectural
//                NZCV register, evaluates branch opcodes against it, and on
//                a taken branch issues a one-cycle redirect followed by a
//                timed flush of the younger pipeline stages.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - branch_condition_controller_if.slave (handshake,
//                       opcode, flags, target, redirect and flush signals)
//  Parameters  : ADDR_W       - branch target / PC width
//                FLUSH_CYCLES - flush length after a taken branch (1..7)
//  Options     : BRANCH_STATS_EN - adds saturating taken / not-taken
//                branch counters (taken_cnt_o, not_taken_cnt_o).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_condition_controller #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  wire                             clk,
    input  wire                             rst,
    branch_condition_controller_if.slave    bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [5:0] OP_BEQ = 6'b001100;
    localparam logic [5:0] OP_BNE = 6'b001101;
    localparam logic [5:0] OP_BGT = 6'b001110;
    localparam logic [5:0] OP_B   = 6'b001111;

    // The flush counter is 3 bits wide, which bounds FLUSH_CYCLES to 1..7.
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q,         state_d;
    logic [3:0]        flags_q,         flags_d;
    logic [2:0]        flush_cnt_q,     flush_cnt_d;
    logic              branch_taken_q,  branch_taken_d;
    logic [ADDR_W-1:0] branch_target_q, branch_target_d;
    logic              flush_q,         flush_d;
`ifdef BRANCH_STATS_EN
    logic [15:0]       taken_cnt_q,     taken_cnt_d;
    logic [15:0]       not_taken_cnt_q, not_taken_cnt_d;
`endif

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic w_ready;
    logic w_accept;
    logic w_is_branch;
    logic w_cond;
    logic w_flag_n;
    logic w_flag_z;
    logic w_flag_v;

    assign w_flag_n = flags_q[3];
    assign w_flag_z = flags_q[2];
    assign w_flag_v = flags_q[0];

    // Conditions only ever look at the registered flags; the ALU flags of
    // the same instruction are written afterwards and never forwarded.
    always_comb begin
        w_cond      = 1'b1;
        w_is_branch = 1'b0;
        case (bus.ex_opcode_i)
            OP_BEQ: begin
                w_is_branch = 1'b1;
                w_cond      = w_flag_z;
            end
            OP_BNE: begin
                w_is_branch = 1'b1;
                w_cond      = ~w_flag_z;
            end
            OP_BGT: begin
                w_is_branch = 1'b1;
                w_cond      = ~w_flag_z && (w_flag_n == w_flag_v);
            end
            OP_B: begin
                w_is_branch = 1'b1;
                w_cond      = 1'b1;
            end
            default: begin
                w_is_branch = 1'b0;
                w_cond      = 1'b1;
            end
        endcase
    end

    // Ready is a pure function of state so that instructions presented
    // during a flush are dropped without any side effect.
    assign w_ready  = (state_q == ST_IDLE);
    assign w_accept = bus.ex_valid_i && w_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        flags_d         = flags_q;
        flush_cnt_d     = flush_cnt_q;
        branch_taken_d  = 1'b0;
        branch_target_d = branch_target_q;
        flush_d         = flush_q;
`ifdef BRANCH_STATS_EN
        taken_cnt_d     = taken_cnt_q;
        not_taken_cnt_d = not_taken_cnt_q;
`endif

        // A branch that also writes flags still commits its new flags;
        // the condition above already used the old ones.
        if (w_accept && bus.ex_flag_write_i) begin
            flags_d = bus.alu_flags_i;
        end

        case (state_q)
            ST_IDLE: begin
                flush_d = 1'b0;
                if (w_accept && w_is_branch && w_cond) begin
                    branch_taken_d  = 1'b1;
                    branch_target_d = bus.ex_target_i;
                    flush_d         = 1'b1;
                    flush_cnt_d     = FLUSH_INIT;
                    state_d         = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush_cnt_d = flush_cnt_q - 3'd1;
                // Leaving on the 1->0 step keeps flush_o high for exactly
                // FLUSH_CYCLES cycles; "<= 1" also recovers from a zero count.
                if (flush_cnt_q <= 3'd1) begin
                    flush_cnt_d = 3'd0;
                    flush_d     = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                flush_d     = 1'b0;
                flush_cnt_d = 3'd0;
            end
        endcase

`ifdef BRANCH_STATS_EN
        // Saturating statistics; accepted branches only occur in IDLE.
        if (w_accept && w_is_branch) begin
            if (w_cond) begin
                if (taken_cnt_q != 16'hFFFF) begin
                    taken_cnt_d = taken_cnt_q + 16'd1;
                end
            end else begin
                if (not_taken_cnt_q != 16'hFFFF) begin
                    not_taken_cnt_d = not_taken_cnt_q + 16'd1;
                end
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            flags_q         <= 4'b0000;
            flush_cnt_q     <= 3'd0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
            flush_q         <= 1'b0;
`ifdef BRANCH_STATS_EN
            taken_cnt_q     <= 16'd0;
            not_taken_cnt_q <= 16'd0;
`endif
        end else begin
            state_q         <= state_d;
            flags_q         <= flags_d;
            flush_cnt_q     <= flush_cnt_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
            flush_q         <= flush_d;
`ifdef BRANCH_STATS_EN
            taken_cnt_q     <= taken_cnt_d;
            not_taken_cnt_q <= not_taken_cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ex_ready_o      = w_ready;
    assign bus.cond_ex_o       = w_cond;
    assign bus.flags_o         = flags_q;
    assign bus.branch_taken_o  = branch_taken_q;
    assign bus.branch_target_o = branch_target_q;
    assign bus.flush_o         = flush_q;
`ifdef BRANCH_STATS_EN
    assign bus.taken_cnt_o     = taken_cnt_q;
    assign bus.not_taken_cnt_o = not_taken_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_condition_controller.sv
// ============================================================================
//  Module      : tb_branch_condition_controller
//  Description : Self-checking bench for branch_condition_controller.
//                Expected outcomes are pushed to a scoreboard queue when an
//                instruction is driven and popped when the result is due.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_condition_controller;

    localparam int ADDR_W       = 32;
    localparam int FLUSH_CYCLES = 2;

    typedef struct packed {
        logic              cond;
        logic              taken;
        logic [ADDR_W-1:0] target;
        logic [3:0]        flags;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_condition_controller_if #(.ADDR_W(ADDR_W)) bus();

    branch_condition_controller #(
        .ADDR_W       (ADDR_W),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t       sb_q[$];
    logic [3:0] mdl_flags;
    int         tests_run    = 0;
    int         tests_failed = 0;

    function automatic logic mdl_cond(input logic [5:0] op, input logic [3:0] f);
        case (op)
            6'b001100: return f[2];
            6'b001101: return ~f[2];
            6'b001110: return ~f[2] && (f[3] == f[0]);
            default:   return 1'b1;
        endcase
    endfunction

    function automatic logic mdl_is_branch(input logic [5:0] op);
        return (op[5:2] == 4'b0011);
    endfunction

    // Drive one instruction for one cycle and record what it should do.
    // acc says whether the controller is expected to accept it.
    task automatic drive_instr(input logic [5:0] op, input logic fw,
                               input logic [3:0] alu, input logic [ADDR_W-1:0] tgt,
                               input logic acc);
        exp_t e;
        @(negedge clk);
        bus.ex_valid_i      = 1'b1;
        bus.ex_opcode_i     = op;
        bus.ex_flag_write_i = fw;
        bus.alu_flags_i     = alu;
        bus.ex_target_i     = tgt;
        e.cond   = mdl_cond(op, mdl_flags);
        e.taken  = acc && mdl_is_branch(op) && e.cond;
        e.target = tgt;
        if (acc && fw) mdl_flags = alu;
        e.flags  = mdl_flags;
        sb_q.push_back(e);
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.ex_valid_i      = 1'b0;
        bus.ex_flag_write_i = 1'b0;
        bus.ex_opcode_i     = 6'b000000;
    endtask

    task automatic test_reset();
        bus.ex_valid_i = 1'b0; bus.ex_opcode_i = '0; bus.ex_flag_write_i = 1'b0;
        bus.alu_flags_i = '0;  bus.ex_target_i = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; mdl_flags = 4'b0000;
        #1;
        tests_run++;
        if (bus.flags_o !== 4'b0000 || bus.flush_o !== 1'b0 || bus.branch_taken_o !== 1'b0 ||
            bus.branch_target_o !== '0 || bus.ex_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset: flags=%b flush=%b taken=%b target=%h ready=%b, required 0000 0 0 0 1",
                     bus.flags_o, bus.flush_o, bus.branch_taken_o, bus.branch_target_o, bus.ex_ready_o);
        end
    endtask

    task automatic test_beq_taken();
        exp_t e;
        drive_instr(6'b000001, 1'b1, 4'b0100, '0, 1'b1);
        @(posedge clk); #1; e = sb_q.pop_front();
        tests_run++;
        if (bus.flags_o !== e.flags) begin
            tests_failed++; $display("FAIL beq_setflags: flags=%b required %b", bus.flags_o, e.flags);
        end
        drive_instr(6'b001100, 1'b0, 4'b0000, 32'h0000_0040, 1'b1);
        #1; tests_run++;
        if (bus.cond_ex_o !== sb_q[0].cond) begin
            tests_failed++; $display("FAIL beq_cond: cond=%b required %b", bus.cond_ex_o, sb_q[0].cond);
        end
        @(posedge clk); #1; e = sb_q.pop_front();
        tests_run++;
        if (bus.branch_taken_o !== e.taken || bus.branch_target_o !== e.target) begin
            tests_failed++;
            $display("FAIL beq_redirect: taken=%b target=%h required %b %h",
                     bus.branch_taken_o, bus.branch_target_o, e.taken, e.target);
        end
        tests_run++;
        if (bus.flush_o !== 1'b1 || bus.ex_ready_o !== 1'b0) begin
            tests_failed++; $display("FAIL beq_flush_start: flush=%b ready=%b required 1 0", bus.flush_o, bus.ex_ready_o);
        end
        go_idle();
        for (int k = 2; k <= FLUSH_CYCLES + 1; k++) begin
            @(posedge clk); #1;
            tests_run++;
            if (bus.flush_o !== (k <= FLUSH_CYCLES) || bus.ex_ready_o !== (k > FLUSH_CYCLES) ||
                bus.branch_taken_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL beq_flush_cycle%0d: flush=%b ready=%b taken=%b required %b %b 0",
                         k, bus.flush_o, bus.ex_ready_o, bus.branch_taken_o,
                         (k <= FLUSH_CYCLES), (k > FLUSH_CYCLES));
            end
        end
    endtask

    task automatic test_bgt();
        exp_t e;
        drive_instr(6'b000010, 1'b1, 4'b1001, '0, 1'b1);
        @(posedge clk); #1; e = sb_q.pop_front();
        drive_instr(6'b001110, 1'b0, 4'b0000, 32'h0000_1234, 1'b1);
        #1; tests_run++;
        if (bus.cond_ex_o !== sb_q[0].cond) begin
            tests_failed++; $display("FAIL bgt_taken_cond: cond=%b required %b", bus.cond_ex_o, sb_q[0].cond);
        end
        @(posedge clk); #1; e = sb_q.pop_front();
        tests_run++;
        if (bus.branch_taken_o !== e.taken || bus.branch_target_o !== e.target || bus.flush_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL bgt_taken: taken=%b target=%h flush=%b required %b %h 1",
                     bus.branch_taken_o, bus.branch_target_o, bus.flush_o, e.taken, e.target);
        end
        go_idle();
        repeat (FLUSH_CYCLES) @(posedge clk);
        drive_instr(6'b000010, 1'b1, 4'b0100, '0, 1'b1);
        @(posedge clk); #1; e = sb_q.pop_front();
        drive_instr(6'b001110, 1'b0, 4'b0000, 32'h0000_5678, 1'b1);
        #1; tests_run++;
        if (bus.cond_ex_o !== sb_q[0].cond) begin
            tests_failed++; $display("FAIL bgt_not_cond: cond=%b required %b", bus.cond_ex_o, sb_q[0].cond);
        end
        @(posedge clk); #1; e = sb_q.pop_front();
        tests_run++;
        if (bus.branch_taken_o !== e.taken || bus.flush_o !== 1'b0 || bus.flags_o !== e.flags ||
            bus.ex_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL bgt_not_taken: taken=%b flush=%b flags=%b ready=%b required %b 0 %b 1",
                     bus.branch_taken_o, bus.flush_o, bus.flags_o, bus.ex_ready_o, e.taken, e.flags);
        end
        go_idle();
    endtask

    task automatic test_flag_and_branch();
        exp_t e;
        drive_instr(6'b000011, 1'b1, 4'b0000, '0, 1'b1);
        @(posedge clk); #1; e = sb_q.pop_front();
        drive_instr(6'b001101, 1'b1, 4'b0100, 32'h0000_0ABC, 1'b1);
        @(posedge clk); #1; e = sb_q.pop_front();
        tests_run++;
        if (bus.branch_taken_o !== e.taken || bus.branch_target_o !== e.target || bus.flags_o !== e.flags) begin
            tests_failed++;
            $display("FAIL bne_with_flagwrite: taken=%b target=%h flags=%b required %b %h %b",
                     bus.branch_taken_o, bus.branch_target_o, bus.flags_o, e.taken, e.target, e.flags);
        end
        go_idle();
        repeat (FLUSH_CYCLES) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        // flags currently 0100; clear Z then immediately test it with BNE/BEQ
        drive_instr(6'b000100, 1'b1, 4'b0000, '0, 1'b1);
        @(posedge clk); #1; e = sb_q.pop_front();
        drive_instr(6'b001100, 1'b0, 4'b0000, 32'h0000_0077, 1'b1);
        #1; tests_run++;
        if (bus.cond_ex_o !== sb_q[0].cond) begin
            tests_failed++; $display("FAIL b2b_cond: cond=%b required %b", bus.cond_ex_o, sb_q[0].cond);
        end
        @(posedge clk); #1; e = sb_q.pop_front();
        tests_run++;
        if (bus.branch_taken_o !== e.taken || bus.flush_o !== 1'b0 || bus.flags_o !== e.flags) begin
            tests_failed++;
            $display("FAIL b2b_beq: taken=%b flush=%b flags=%b required %b 0 %b",
                     bus.branch_taken_o, bus.flush_o, bus.flags_o, e.taken, e.flags);
        end
        go_idle();
    endtask

    task automatic test_flush_ignore();
        exp_t e;
        drive_instr(6'b001111, 1'b0, 4'b0000, 32'h0000_0100, 1'b1);
        @(posedge clk); #1; e = sb_q.pop_front();
        tests_run++;
        if (bus.branch_taken_o !== e.taken || bus.branch_target_o !== e.target) begin
            tests_failed++;
            $display("FAIL flush_b_taken: taken=%b target=%h required %b %h",
                     bus.branch_taken_o, bus.branch_target_o, e.taken, e.target);
        end
        for (int k = 1; k <= FLUSH_CYCLES; k++) begin
            drive_instr(6'b001111, 1'b1, 4'b1111, 32'h0000_0999, 1'b0);
            @(posedge clk); #1; e = sb_q.pop_front();
            tests_run++;
            if (bus.flags_o !== e.flags || bus.branch_taken_o !== 1'b0 ||
                bus.flush_o !== (k < FLUSH_CYCLES) || bus.ex_ready_o !== (k >= FLUSH_CYCLES)) begin
                tests_failed++;
                $display("FAIL flush_ignore%0d: flags=%b taken=%b flush=%b ready=%b required %b 0 %b %b",
                         k, bus.flags_o, bus.branch_taken_o, bus.flush_o, bus.ex_ready_o,
                         e.flags, (k < FLUSH_CYCLES), (k >= FLUSH_CYCLES));
            end
        end
        drive_instr(6'b001111, 1'b0, 4'b0000, 32'h0000_0200, 1'b1);
        @(posedge clk); #1; e = sb_q.pop_front();
        tests_run++;
        if (bus.branch_taken_o !== e.taken || bus.branch_target_o !== e.target || bus.flush_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_then_b: taken=%b target=%h flush=%b required %b %h 1",
                     bus.branch_taken_o, bus.branch_target_o, bus.flush_o, e.taken, e.target);
        end
        go_idle();
        repeat (FLUSH_CYCLES) @(posedge clk);
    endtask

    task automatic test_reset_in_flush();
        exp_t e;
        drive_instr(6'b000101, 1'b1, 4'b1001, '0, 1'b1);
        @(posedge clk); #1; e = sb_q.pop_front();
        drive_instr(6'b001111, 1'b0, 4'b0000, 32'h0000_0300, 1'b1);
        @(posedge clk); #1; e = sb_q.pop_front();
        @(negedge clk);
        rst = 1'b1; bus.ex_valid_i = 1'b0; bus.ex_flag_write_i = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (bus.flush_o !== 1'b0 || bus.ex_ready_o !== 1'b1 || bus.flags_o !== 4'b0000 ||
            bus.branch_taken_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_flush: flush=%b ready=%b flags=%b taken=%b required 0 1 0000 0",
                     bus.flush_o, bus.ex_ready_o, bus.flags_o, bus.branch_taken_o);
        end
        @(negedge clk); rst = 1'b0; mdl_flags = 4'b0000;
        drive_instr(6'b000000, 1'b0, 4'b0000, 32'h0000_0400, 1'b1);
        #1; tests_run++;
        if (bus.cond_ex_o !== sb_q[0].cond) begin
            tests_failed++; $display("FAIL post_reset_cond: cond=%b required %b", bus.cond_ex_o, sb_q[0].cond);
        end
        @(posedge clk); #1; e = sb_q.pop_front();
        tests_run++;
        if (bus.branch_taken_o !== e.taken || bus.flush_o !== 1'b0 || bus.flags_o !== e.flags) begin
            tests_failed++;
            $display("FAIL post_reset_nonbranch: taken=%b flush=%b flags=%b required %b 0 %b",
                     bus.branch_taken_o, bus.flush_o, bus.flags_o, e.taken, e.flags);
        end
        go_idle();
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        exp_t e;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; mdl_flags = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            drive_instr(6'b001111, 1'b0, 4'b0000, 32'h0000_0500, 1'b1);
            @(posedge clk); #1; e = sb_q.pop_front();
            go_idle();
            repeat (FLUSH_CYCLES) @(posedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            drive_instr(6'b001100, 1'b0, 4'b0000, 32'h0000_0600, 1'b1);
            @(posedge clk); #1; e = sb_q.pop_front();
        end
        go_idle();
        #1; tests_run++;
        if (bus.taken_cnt_o !== 16'd3 || bus.not_taken_cnt_o !== 16'd2) begin
            tests_failed++;
            $display("FAIL stats_counts: taken=%0d not_taken=%0d required 3 2",
                     bus.taken_cnt_o, bus.not_taken_cnt_o);
        end
        // Hold a not-taken BEQ long enough to run the counter into saturation.
        @(negedge clk);
        bus.ex_valid_i = 1'b1; bus.ex_opcode_i = 6'b001100; bus.ex_flag_write_i = 1'b0;
        repeat (65540) @(posedge clk);
        #1; tests_run++;
        if (bus.not_taken_cnt_o !== 16'hFFFF || bus.taken_cnt_o !== 16'd3) begin
            tests_failed++;
            $display("FAIL stats_saturate: not_taken=%h taken=%0d required ffff 3",
                     bus.not_taken_cnt_o, bus.taken_cnt_o);
        end
        go_idle();
    endtask
`endif

    initial begin
        mdl_flags = 4'b0000;
        test_reset();
        test_beq_taken();
        test_bgt();
        test_flag_and_branch();
        test_back_to_back();
        test_flush_ignore();
        test_reset_in_flush();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
